// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-enabled data RAM, 64-bit cycle counter and
// a memory-mapped TX byte FIFO drained over a valid/ready stream.
module dmem_responder #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWrite,
    input  logic [3:0]      MemWriteSelect,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] ReadData,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;
    localparam int unsigned WA_W    = XLEN - 2;

    localparam logic [WA_W-1:0] A_TXDATA   = WA_W'(32'h1000_0000 >> 2);
    localparam logic [WA_W-1:0] A_STATUS   = WA_W'(32'h1000_0004 >> 2);
    localparam logic [WA_W-1:0] A_CYCLE_LO = WA_W'(32'h1000_0008 >> 2);
    localparam logic [WA_W-1:0] A_CYCLE_HI = WA_W'(32'h1000_000C >> 2);

    logic [XLEN-1:0]    r_ram [RAM_WORDS];
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [63:0]        r_cycle;

    logic [WA_W-1:0]    w_word;
    logic               w_is_ram;
    logic [RAM_AW-1:0]  w_ram_idx;
    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_set;
    logic               w_ovf_clr;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [XLEN-1:0]    w_status;
    logic               w_unused;

    // Word-granular decode; the byte offset within a word is don't-care.
    assign w_word    = ALUResult[XLEN-1:2];
    assign w_is_ram  = (ALUResult[XLEN-1:RAM_AW+2] == '0);
    assign w_ram_idx = ALUResult[RAM_AW+1:2];
    assign w_unused  = &{1'b0, ALUResult[1:0]};

    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign tx_valid   = !w_empty;
    assign tx_data    = tx_valid ? r_fifo[r_rd_ptr] : 8'h00;

    assign w_pop      = tx_valid & tx_ready;
    assign w_push_req = MemWrite & MemWriteSelect[0] & (w_word == A_TXDATA);
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign w_push     = w_push_req & (!w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & !w_pop;
    assign w_ovf_clr  = MemWrite & MemWriteSelect[0] & (w_word == A_STATUS) & WriteData[2];

    assign w_status = XLEN'({8'(r_count), 5'b0, r_overflow, w_empty, w_full});

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = CNT_W'(r_count + CNT_W'(1));
        end else if (w_pop && !w_push) begin
            w_count_nxt = CNT_W'(r_count - CNT_W'(1));
        end
    end

    // Load data mux: RAM, then memory-mapped registers, otherwise zero.
    always_comb begin
        ReadData = '0;
        if (w_is_ram) begin
            ReadData = r_ram[w_ram_idx];
        end else begin
            case (w_word)
                A_STATUS:   ReadData = w_status;
                A_CYCLE_LO: ReadData = r_cycle[31:0];
                A_CYCLE_HI: ReadData = r_cycle[63:32];
                default:    ReadData = '0;
            endcase
        end
    end

    // Data RAM holds its contents across reset.
    always_ff @(posedge clk) begin
        if (MemWrite && w_is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (MemWriteSelect[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= FIFO_AW'(r_wr_ptr + FIFO_AW'(1));
            end
            if (w_pop) begin
                r_rd_ptr <= FIFO_AW'(r_rd_ptr + FIFO_AW'(1));
            end
            r_count <= w_count_nxt;
            // A new overflow takes priority over a software clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written corner
// sequences, and a randomized run against a queue/array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] TXD = 32'h1000_0000;
    localparam logic [31:0] STA = 32'h1000_0004;
    localparam logic [31:0] CLO = 32'h1000_0008;
    localparam logic [31:0] CHI = 32'h1000_000C;
    localparam logic [31:0] UNM = 32'h1000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [3:0]  MemWriteSelect = 4'h0;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    dmem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .MemWrite       (MemWrite),
        .MemWriteSelect (MemWriteSelect),
        .ALUResult      (ALUResult),
        .WriteData      (WriteData),
        .ReadData       (ReadData),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        ck_rd;
        logic [31:0] rd;
        logic        vld;
        logic [7:0]  dat;
    } vec_t;

    vec_t tbl [15];

    // Reference model state
    logic [31:0] m_ram [256];
    logic [3:0]  m_bv  [256];
    logic [7:0]  q [$];
    logic        m_ovf;
    logic [63:0] m_cycle;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] wd, input logic rdy);
        MemWrite       = we;
        MemWriteSelect = sel;
        ALUResult      = a;
        WriteData      = wd;
        tx_ready       = rdy;
        #1;
    endtask

    task automatic model_expect(input logic [31:0] a, output logic [31:0] exp, output logic [31:0] mask);
        logic [7:0] idx;
        exp  = 32'h0;
        mask = 32'hFFFF_FFFF;
        idx  = a[9:2];
        if (a < 32'd1024) begin
            exp = m_ram[idx];
            for (int l = 0; l < 4; l++) mask[8*l +: 8] = {8{m_bv[idx][l]}};
        end else if (a[31:2] == STA[31:2]) begin
            exp = {16'h0, 8'(q.size()), 5'b0, m_ovf, q.size() == 0, q.size() == DEPTH};
        end else if (a[31:2] == CLO[31:2]) begin
            exp = m_cycle[31:0];
        end else if (a[31:2] == CHI[31:2]) begin
            exp = m_cycle[63:32];
        end
    endtask

    task automatic model_edge(input logic we, input logic [3:0] sel, input logic [31:0] a,
                              input logic [31:0] wd, input logic rdy);
        logic pop, push_req, set, clr;
        logic [7:0] idx;
        idx      = a[9:2];
        pop      = (q.size() != 0) && rdy;
        push_req = we && sel[0] && (a[31:2] == TXD[31:2]);
        set      = push_req && (q.size() == DEPTH) && !pop;
        clr      = we && sel[0] && (a[31:2] == STA[31:2]) && wd[2];
        if (pop) void'(q.pop_front());
        if (push_req && !set) q.push_back(wd[7:0]);
        m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
        if (we && a < 32'd1024) begin
            for (int l = 0; l < 4; l++) begin
                if (sel[l]) begin
                    m_ram[idx][8*l +: 8] = wd[8*l +: 8];
                    m_bv[idx][l] = 1'b1;
                end
            end
        end
        m_cycle = m_cycle + 64'd1;
    endtask

    initial begin
        logic [7:0]  exp_b [8];
        logic [31:0] a, wd, exp, mask;
        logic        we, rdy;
        logic [3:0]  sel;

        tbl[0]  = '{1'b1, 4'hF, 32'h40,     32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00};
        tbl[1]  = '{1'b1, 4'h1, 32'h40,     32'h000000AA, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 4'h0, 32'h40,     32'h0,        1'b0, 1'b1, 32'hDEADBEAA, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 4'h0, 32'h41,     32'h0,        1'b0, 1'b1, 32'hDEADBEAA, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 4'h1, TXD,        32'h11,       1'b0, 1'b1, 32'h0,        1'b0, 8'h00};
        tbl[5]  = '{1'b1, 4'h1, TXD,        32'h22,       1'b0, 1'b1, 32'h0,        1'b1, 8'h11};
        tbl[6]  = '{1'b1, 4'h1, TXD,        32'h33,       1'b0, 1'b1, 32'h0,        1'b1, 8'h11};
        tbl[7]  = '{1'b0, 4'h0, STA,        32'h0,        1'b0, 1'b1, 32'h0000_0300, 1'b1, 8'h11};
        tbl[8]  = '{1'b0, 4'h0, STA,        32'h0,        1'b1, 1'b1, 32'h0000_0300, 1'b1, 8'h11};
        tbl[9]  = '{1'b0, 4'h0, STA,        32'h0,        1'b1, 1'b1, 32'h0000_0200, 1'b1, 8'h22};
        tbl[10] = '{1'b0, 4'h0, STA,        32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b1, 8'h33};
        tbl[11] = '{1'b0, 4'h0, STA,        32'h0,        1'b1, 1'b1, 32'h0000_0002, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 4'h0, UNM,        32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 8'h00};
        tbl[13] = '{1'b1, 4'hF, UNM,        32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1'b0, 8'h00};
        tbl[14] = '{1'b0, 4'h0, 32'h40,     32'h0,        1'b0, 1'b1, 32'hDEADBEAA, 1'b0, 8'h00};

        // Reset state and counter start
        #2 reset = 1'b0;
        repeat (3) step();
        drive(1'b0, 4'h0, STA, 32'h0, 1'b0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_status", 64'(ReadData), 64'h2);
        drive(1'b0, 4'h0, CLO, 32'h0, 1'b0);
        chk("rst_cycle_lo", 64'(ReadData), 64'd0);
        reset = 1'b1;
        #1 chk("cycle_before_edge", 64'(ReadData), 64'd0);
        repeat (5) step();
        chk("cycle_after5", 64'(ReadData), 64'd5);

        // Counter carry from low to high half
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.r_cycle;
        #1 chk("cycle_lo_forced", 64'(ReadData), 64'hFFFF_FFFF);
        step();
        chk("cycle_lo_carry", 64'(ReadData), 64'd0);
        drive(1'b0, 4'h0, CHI, 32'h0, 1'b0);
        chk("cycle_hi_carry", 64'(ReadData), 64'd1);

        // Directed vector table: RAM lanes, FIFO order, unmapped space
        for (int i = 0; i < 15; i++) begin
            step();
            drive(tbl[i].we, tbl[i].sel, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
            if (tbl[i].ck_rd) chk($sformatf("tbl%0d_rd", i), 64'(ReadData), 64'(tbl[i].rd));
            chk($sformatf("tbl%0d_valid", i), 64'(tx_valid), 64'(tbl[i].vld));
            chk($sformatf("tbl%0d_data", i), 64'(tx_data), 64'(tbl[i].dat));
        end

        // Overflow: nine pushes into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            step();
            drive(1'b1, 4'h1, TXD, 32'(i), 1'b0);
        end
        step();
        drive(1'b0, 4'h0, STA, 32'h0, 1'b0);
        chk("ovf_status", 64'(ReadData), 64'h805);
        chk("ovf_head", 64'(tx_data), 64'h01);
        step();
        drive(1'b1, 4'h1, STA, 32'h4, 1'b0);
        chk("ovf_clr_pre", 64'(ReadData), 64'h805);
        step();
        drive(1'b0, 4'h0, STA, 32'h0, 1'b0);
        chk("ovf_cleared", 64'(ReadData), 64'h801);

        // Full FIFO with push and pop in the same cycle
        step();
        drive(1'b1, 4'h1, TXD, 32'h77, 1'b1);
        chk("fullpp_head", 64'(tx_data), 64'h01);
        step();
        drive(1'b0, 4'h0, STA, 32'h0, 1'b1);
        chk("fullpp_status", 64'(ReadData), 64'h801);
        for (int i = 0; i < 7; i++) exp_b[i] = 8'(i + 2);
        exp_b[7] = 8'h77;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), 64'(tx_valid), 64'd1);
            chk($sformatf("drain%0d_data", i), 64'(tx_data), 64'(exp_b[i]));
            step();
        end
        chk("drain_end_valid", 64'(tx_valid), 64'd0);
        chk("drain_end_status", 64'(ReadData), 64'h2);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 4'h1, TXD, 32'hA0 + 32'(i), 1'b0);
        end
        step();
        drive(1'b0, 4'h0, STA, 32'h0, 1'b1);
        chk("mid_head", 64'(tx_data), 64'hA0);
        step();
        chk("mid_next", 64'(tx_data), 64'hA1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(tx_valid), 64'd0);
        chk("mid_rst_data", 64'(tx_data), 64'd0);
        step();
        reset = 1'b1;
        drive(1'b0, 4'h0, STA, 32'h0, 1'b0);
        chk("mid_rst_status", 64'(ReadData), 64'h2);
        drive(1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
        chk("mid_rst_ram", 64'(ReadData), 64'hDEADBEAA);

        // Randomized run from a fresh reset against the model
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) m_bv[i] = 4'h0;
        m_ram[16] = 32'hDEADBEAA;
        m_bv[16]  = 4'hF;
        q.delete();
        m_ovf   = 1'b0;
        m_cycle = 64'd0;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, 255));
                4:          a = 32'h3FC | 32'($urandom_range(0, 3));
                5:          a = 32'h400 | 32'($urandom_range(0, 3));
                6, 7:       a = TXD | 32'($urandom_range(0, 3));
                8:          a = STA;
                default: begin
                    case ($urandom_range(0, 2))
                        0:       a = CLO;
                        1:       a = CHI;
                        default: a = UNM;
                    endcase
                end
            endcase
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            wd  = $urandom;
            rdy = ($urandom_range(0, 2) == 0);
            drive(we, sel, a, wd, rdy);
            model_expect(a, exp, mask);
            if (mask != 32'h0) chk("rand_rd", 64'(ReadData & mask), 64'(exp & mask));
            chk("rand_valid", 64'(tx_valid), 64'(q.size() != 0));
            chk("rand_data", 64'(tx_data), 64'((q.size() != 0) ? q[0] : 8'h00));
            model_edge(we, sel, a, wd, rdy);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the pipelined RISC-V core. It answers the core's memory-stage data port and contains:
- a byte-enabled data RAM;
- a free-running 64-bit cycle counter;
- a transmit FIFO that drains bytes over a valid/ready stream.

Reads are combinational, so the core's M stage sees `ReadData` in the same cycle. All state updates on the rising edge of `clk`.

## Interface
- `XLEN`, 32, data/address width (only 32 supported).
- `RAM_WORDS`, 256, data RAM depth in 32-bit words (power of two).
- `FIFO_DEPTH`, 8, TX FIFO depth in bytes (power of two, ≥2).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: store strobe from core M stage.
- `MemWriteSelect` in 4: byte enables for the store; bit i covers `WriteData[8i+7:8i]`.
- `ALUResult` in XLEN: byte address from core.
- `WriteData` in XLEN: store data.
- `ReadData` out XLEN: combinational load data.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: sink accepts the head byte.

## Operation
Address decode uses `ALUResult[31:2]`; bits [1:0] are ignored.
- RAM: `ALUResult < RAM_WORDS*4`. Index is `ALUResult[log2(RAM_WORDS)+1:2]`.
- `0x1000_0000` TXDATA:
  - Write with `MemWriteSelect[0]=1` pushes `WriteData[7:0]`.
  - Reads return 0.
- `0x1000_0004` STATUS (read):
  - bit0 full, bit1 empty, bit2 overflow (sticky).
  - bits[15:8] = FIFO count, zero-extended; all other bits 0.
  - Write with `MemWriteSelect[0]=1` and `WriteData[2]=1` clears overflow.
- `0x1000_0008` CYCLE_LO and `0x1000_000C` CYCLE_HI: read-only halves of the counter; writes are ignored.
- Unmapped addresses: reads return 0, writes are ignored.

RAM:
- Store when `MemWrite=1`: each enabled byte lane is written; disabled lanes are unchanged.
- RAM is not reset; contents are undefined until written.

Cycle counter:
- 64-bit, cleared by reset, +1 every clock edge while `reset=1`.
- Wraps from 2^64-1 to 0.

TX FIFO (circular buffer with read/write pointers and a count):
- Push: `MemWrite & MemWriteSelect[0]` and address = TXDATA.
- Pop: `tx_valid & tx_ready`.
- `tx_valid = (count != 0)`. `tx_data` = head byte when non-empty, 0 when empty.
- Push while full with no pop in the same cycle: byte is dropped, overflow set.
- Push and pop in the same cycle, FIFO full: both occur, count unchanged, no overflow.
- Push and pop in the same cycle, otherwise: both occur, count unchanged.
- Pop when empty cannot happen, because `tx_valid=0`.
- Pointers wrap modulo `FIFO_DEPTH`.
- If an overflow-set event and a clear write fall in the same cycle, set wins.

## Timing
- `ReadData` is combinational from address and current register/RAM state. A store at edge N is visible to reads after edge N.
- STATUS and CYCLE reads return pre-edge register values.
- The first edge after `reset` deasserts increments the counter to 1; a CYCLE_LO read before that edge returns 0.
- Push accepted at edge N: `tx_valid` is high, with `tx_data` = that byte, from N to N+1 if the FIFO was empty.
- Pop at edge N: the next byte, or `tx_valid=0`, follows after the edge.
- Sink handshake: `tx_data`/`tx_valid` stay stable until accepted.
- Reset assertion (asynchronous, at any time, including mid-drain) immediately forces:
  - `tx_valid=0`, `tx_data=0`;
  - count 0, pointers 0, overflow 0, counter 0.
  - RAM is unaffected.
- Reset values of outputs: `tx_valid=0`, `tx_data=0`. `ReadData` = 0 for any non-RAM address.

## Test plan
- RAM byte lanes:
  - Store `0xDEADBEEF` to `0x40` with select `1111`, then store `0x000000AA` with select `0001`.
  - Required: load `0x40` returns `0xDEADBEAA`; load `0x41` returns the same word.
- FIFO order:
  - Push `0x11, 0x22, 0x33` with `tx_ready=0`, then raise `tx_ready`.
  - Required: STATUS count = 3, empty = 0; bytes drain as `0x11, 0x22, 0x33` on consecutive cycles, then `tx_valid=0` and STATUS empty = 1.
- Overflow:
  - Push 9 bytes with `tx_ready=0` (depth 8).
  - Required: full = 1, overflow = 1, count = 8, 9th byte lost.
  - Then write STATUS with `0x4`: overflow = 0 next cycle.
- Full with simultaneous push and pop:
  - FIFO full, `tx_ready=1`, push `0x77` in the same cycle.
  - Required: count stays 8, no overflow, `0x77` emerges last.
- Counter:
  - Release reset, read CYCLE_LO after 5 edges.
  - Required: 5.
  - Force the counter to `0x0000_0000_FFFF_FFFF`; after one edge, CYCLE_HI=1 and CYCLE_LO=0.
- Reset mid-drain:
  - Assert `reset=0` with 4 bytes queued between clock edges.
  - Required: `tx_valid` drops immediately; after release, STATUS = `0x0000_0002` and earlier RAM data is preserved.
